// File: rtl/hazard_control.sv
// ---------------------------------------------------------------------------
// hazard_control
//   Register-tag pipeline and interlock for the 5-stage MIPS core. Carries
//   source/destination register tags from ID through EX, MEM and WB, feeds
//   the forwarding unit, and detects the hazards forwarding cannot cover
//   (load-use and ID-stage branch compare). On a hazard it freezes PC and
//   IF/ID and injects a bubble into ID/EX.
//
//   Optional feature: define HAZARD_STATS_EN to enable the saturating
//   stall_cycles counter; otherwise stall_cycles is tied to 0.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs, id_rt              source register fields in ID
//   id_uses_rs, id_uses_rt    ID instruction reads rs / rt
//   id_write_reg              destination register in ID
//   id_reg_write              ID instruction writes the register file
//   id_mem_to_reg             ID instruction is a load
//   id_branch                 ID instruction compares rs/rt in ID
//   ext_stall                 memory-system freeze of the whole pipeline
//   pc_write, if_id_write     PC / IF-ID load enables
//   id_ex_bubble              zero the control fields loaded into ID/EX
//   ex_rs, ex_rt              source tags in EX
//   mem_write_reg/reg_write   destination tag / write flag in MEM
//   wb_write_reg/reg_write    destination tag / write flag in WB
//   stall_cycles              hazard stall cycle count
// ---------------------------------------------------------------------------
module hazard_control #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  id_write_reg,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             ext_stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic [RA_W-1:0]  ex_rs,
    output logic [RA_W-1:0]  ex_rt,
    output logic [RA_W-1:0]  mem_write_reg,
    output logic             mem_reg_write,
    output logic [RA_W-1:0]  wb_write_reg,
    output logic             wb_reg_write,
    output logic [CNT_W-1:0] stall_cycles
);

    // EX stage
    logic [RA_W-1:0] ex_rs_q, ex_rs_d;
    logic [RA_W-1:0] ex_rt_q, ex_rt_d;
    logic [RA_W-1:0] ex_write_reg_q, ex_write_reg_d;
    logic            ex_reg_write_q, ex_reg_write_d;
    logic            ex_mem_to_reg_q, ex_mem_to_reg_d;
    // MEM stage
    logic [RA_W-1:0] mem_write_reg_q, mem_write_reg_d;
    logic            mem_reg_write_q, mem_reg_write_d;
    logic            mem_mem_to_reg_q, mem_mem_to_reg_d;
    // WB stage
    logic [RA_W-1:0] wb_write_reg_q, wb_write_reg_d;
    logic            wb_reg_write_q, wb_reg_write_d;

    logic load_use, br_ex, br_mem, hz;

    // True when a nonzero tag r is read by the instruction in ID. r0 is
    // hard-wired zero, so a write to it never creates a dependency.
    function automatic logic id_reads(input logic [RA_W-1:0] r,
                                      input logic [RA_W-1:0] rs,
                                      input logic [RA_W-1:0] rt,
                                      input logic            urs,
                                      input logic            urt);
        return (r != '0) && ((urs && (r == rs)) || (urt && (r == rt)));
    endfunction

    always_comb begin
        load_use = ex_reg_write_q && ex_mem_to_reg_q &&
                   id_reads(ex_write_reg_q, id_rs, id_rt, id_uses_rs, id_uses_rt);
        br_ex    = id_branch && ex_reg_write_q &&
                   id_reads(ex_write_reg_q, id_rs, id_rt, id_uses_rs, id_uses_rt);
        br_mem   = id_branch && mem_reg_write_q && mem_mem_to_reg_q &&
                   id_reads(mem_write_reg_q, id_rs, id_rt, id_uses_rs, id_uses_rt);
        hz       = id_valid && (load_use || br_ex || br_mem);
    end

    always_comb begin
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            pc_write     = !ext_stall && !hz;
            if_id_write  = !ext_stall && !hz;
            id_ex_bubble = hz && !ext_stall;
        end
    end

    always_comb begin
        // Default: hold everything (covers ext_stall freeze).
        ex_rs_d          = ex_rs_q;
        ex_rt_d          = ex_rt_q;
        ex_write_reg_d   = ex_write_reg_q;
        ex_reg_write_d   = ex_reg_write_q;
        ex_mem_to_reg_d  = ex_mem_to_reg_q;
        mem_write_reg_d  = mem_write_reg_q;
        mem_reg_write_d  = mem_reg_write_q;
        mem_mem_to_reg_d = mem_mem_to_reg_q;
        wb_write_reg_d   = wb_write_reg_q;
        wb_reg_write_d   = wb_reg_write_q;
        if (!ext_stall) begin
            wb_write_reg_d   = mem_write_reg_q;
            wb_reg_write_d   = mem_reg_write_q;
            mem_write_reg_d  = ex_write_reg_q;
            mem_reg_write_d  = ex_reg_write_q;
            mem_mem_to_reg_d = ex_mem_to_reg_q;
            if (hz || !id_valid) begin
                // Bubble: a stalled or empty ID slot enters EX as all zeros.
                ex_rs_d         = '0;
                ex_rt_d         = '0;
                ex_write_reg_d  = '0;
                ex_reg_write_d  = 1'b0;
                ex_mem_to_reg_d = 1'b0;
            end else begin
                ex_rs_d         = id_rs;
                ex_rt_d         = id_rt;
                ex_write_reg_d  = id_write_reg;
                ex_reg_write_d  = id_reg_write;
                ex_mem_to_reg_d = id_mem_to_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs_q          <= '0;
            ex_rt_q          <= '0;
            ex_write_reg_q   <= '0;
            ex_reg_write_q   <= 1'b0;
            ex_mem_to_reg_q  <= 1'b0;
            mem_write_reg_q  <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            wb_write_reg_q   <= '0;
            wb_reg_write_q   <= 1'b0;
        end else begin
            ex_rs_q          <= ex_rs_d;
            ex_rt_q          <= ex_rt_d;
            ex_write_reg_q   <= ex_write_reg_d;
            ex_reg_write_q   <= ex_reg_write_d;
            ex_mem_to_reg_q  <= ex_mem_to_reg_d;
            mem_write_reg_q  <= mem_write_reg_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            wb_write_reg_q   <= wb_write_reg_d;
            wb_reg_write_q   <= wb_reg_write_d;
        end
    end

    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign mem_write_reg = mem_write_reg_q;
    assign mem_reg_write = mem_reg_write_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_reg_write  = wb_reg_write_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    // Counts only hazard stalls that actually take effect; saturates.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (hz && !ext_stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// ---------------------------------------------------------------------------
// tb_hazard_control
//   Cycle-by-cycle vector table for hazard_control: each row gives the ID
//   inputs for one cycle and the outputs expected before the next edge.
//   A hand-written sequence afterwards exercises stall_cycles with CNT_W=2.
// ---------------------------------------------------------------------------
module tb_hazard_control;

    localparam int RA_W  = 5;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs, id_rt, id_write_reg;
    logic             id_uses_rs, id_uses_rt, id_reg_write, id_mem_to_reg;
    logic             id_branch, ext_stall;
    logic             pc_write, if_id_write, id_ex_bubble;
    logic [RA_W-1:0]  ex_rs, ex_rt, mem_write_reg, wb_write_reg;
    logic             mem_reg_write, wb_reg_write;
    logic [CNT_W-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    hazard_control #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_write_reg  (id_write_reg),
        .id_reg_write  (id_reg_write),
        .id_mem_to_reg (id_mem_to_reg),
        .id_branch     (id_branch),
        .ext_stall     (ext_stall),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .id_ex_bubble  (id_ex_bubble),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_write_reg (mem_write_reg),
        .mem_reg_write (mem_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_reg_write  (wb_reg_write),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, vld;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] wr;
        logic       rw, m2r, br, xs;
        logic       e_pc, e_bub;
        logic [4:0] e_exrs, e_exrt, e_memwr;
        logic       e_memrw;
        logic [4:0] e_wbwr;
        logic       e_wbrw;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input int rs, input int rt,
                       input logic urs, input logic urt, input int wr,
                       input logic rw, input logic m2r, input logic br,
                       input logic xs, input logic pc, input logic bub,
                       input int exrs, input int exrt, input int memwr,
                       input logic memrw, input int wbwr, input logic wbrw);
        vec_t t;
        t.rst = r; t.vld = v; t.rs = rs[4:0]; t.rt = rt[4:0];
        t.urs = urs; t.urt = urt; t.wr = wr[4:0]; t.rw = rw; t.m2r = m2r;
        t.br = br; t.xs = xs; t.e_pc = pc; t.e_bub = bub;
        t.e_exrs = exrs[4:0]; t.e_exrt = exrt[4:0]; t.e_memwr = memwr[4:0];
        t.e_memrw = memrw; t.e_wbwr = wbwr[4:0]; t.e_wbrw = wbrw;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; id_valid = t.vld; id_rs = t.rs; id_rt = t.rt;
        id_uses_rs = t.urs; id_uses_rt = t.urt; id_write_reg = t.wr;
        id_reg_write = t.rw; id_mem_to_reg = t.m2r; id_branch = t.br;
        ext_stall = t.xs;
    endtask

    initial begin
        vec_t idle;
        vec_t a, b;
        int   exp_cnt;

        idle = '{default: '0};
        //  rst vld rs rt urs urt wr rw m2r br xs | pc bub exrs exrt memwr memrw wbwr wbrw
        add(1,1, 1,2, 1,1, 3,1,0,0,0,  0,1, 0,0, 0,0, 0,0);  // reset, 2nd clock
        add(0,1, 2,5, 1,0, 5,1,1,0,0,  1,0, 0,0, 0,0, 0,0);  // lw $5
        add(0,1, 5,4, 1,1, 3,1,0,0,0,  0,1, 2,5, 0,0, 0,0);  // add uses $5: stall
        add(0,1, 5,4, 1,1, 3,1,0,0,0,  1,0, 0,0, 5,1, 0,0);  // released
        add(0,1, 3,6, 1,1, 0,0,0,1,0,  0,1, 5,4, 0,0, 5,1);  // beq on ALU $3 in EX
        add(0,1, 3,6, 1,1, 0,0,0,1,0,  1,0, 0,0, 3,1, 0,0);  // ALU in MEM: no stall
        add(0,1, 2,6, 1,0, 6,1,1,0,0,  1,0, 3,6, 0,0, 3,1);  // lw $6
        add(0,1, 5,6, 1,1, 0,0,0,1,0,  0,1, 2,6, 0,0, 0,0);  // beq: load in EX
        add(0,1, 5,6, 1,1, 0,0,0,1,0,  0,1, 0,0, 6,1, 0,0);  // beq: load in MEM
        add(0,1, 5,6, 1,1, 0,0,0,1,0,  1,0, 0,0, 0,0, 6,1);  // released
        add(0,1, 2,6, 1,0, 6,1,1,0,0,  1,0, 5,6, 0,0, 0,0);  // lw $6
        add(0,1, 1,2, 1,1, 7,1,0,0,0,  1,0, 2,6, 0,0, 0,0);  // independent add $7
        add(0,1, 5,6, 1,1, 0,0,0,1,0,  0,1, 1,2, 6,1, 0,0);  // beq: lw $6 in MEM
        add(0,1, 5,6, 1,1, 0,0,0,1,0,  1,0, 0,0, 7,1, 6,1);  // released
        add(0,1, 2,0, 1,0, 0,1,1,0,0,  1,0, 5,6, 0,0, 7,1);  // lw $0
        add(0,1, 0,0, 1,1, 8,1,0,0,0,  1,0, 2,0, 0,0, 0,0);  // reads $0: no stall
        add(0,1, 2,7, 1,0, 7,1,1,0,0,  1,0, 0,0, 0,1, 0,0);  // lw $7
        add(0,1, 7,7, 0,0, 9,1,0,0,0,  1,0, 2,7, 8,1, 0,1);  // $7 not used: no stall
        add(0,1, 2,5, 1,0, 5,1,1,0,0,  1,0, 7,7, 7,1, 8,1);  // lw $5
        add(0,1, 5,4, 1,1, 3,1,0,0,1,  0,0, 2,5, 9,1, 7,1);  // ext_stall 1/3
        add(0,1, 5,4, 1,1, 3,1,0,0,1,  0,0, 2,5, 9,1, 7,1);  // ext_stall 2/3
        add(0,1, 5,4, 1,1, 3,1,0,0,1,  0,0, 2,5, 9,1, 7,1);  // ext_stall 3/3
        add(0,1, 5,4, 1,1, 3,1,0,0,0,  0,1, 2,5, 9,1, 7,1);  // hazard stall
        add(0,1, 5,4, 1,1, 3,1,0,0,0,  1,0, 0,0, 5,1, 9,1);  // released
        add(0,0, 3,4, 1,1,10,1,0,0,0,  1,0, 5,4, 0,0, 5,1);  // invalid ID
        add(1,1, 5,4, 1,1, 3,1,0,0,0,  0,1, 0,0, 3,1, 0,0);  // reset mid-run
        add(0,0, 0,0, 0,0, 0,0,0,0,0,  1,0, 0,0, 0,0, 0,0);  // post-reset idle

        // First reset clock: state is unknown before it.
        drive(idle);
        rst = 1'b1;
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d pc_write", i),      pc_write,      vecs[i].e_pc);
            check($sformatf("row%0d if_id_write", i),   if_id_write,   vecs[i].e_pc);
            check($sformatf("row%0d id_ex_bubble", i),  id_ex_bubble,  vecs[i].e_bub);
            check($sformatf("row%0d ex_rs", i),         ex_rs,         vecs[i].e_exrs);
            check($sformatf("row%0d ex_rt", i),         ex_rt,         vecs[i].e_exrt);
            check($sformatf("row%0d mem_write_reg", i), mem_write_reg, vecs[i].e_memwr);
            check($sformatf("row%0d mem_reg_write", i), mem_reg_write, vecs[i].e_memrw);
            check($sformatf("row%0d wb_write_reg", i),  wb_write_reg,  vecs[i].e_wbwr);
            check($sformatf("row%0d wb_reg_write", i),  wb_reg_write,  vecs[i].e_wbrw);
            check($sformatf("row%0d stall_cycles", i),  stall_cycles,  0);
        end

        // stall_cycles: "lw $5, 0($5)" repeated gives a load-use stall every
        // other cycle. Counter saturates at 3 with CNT_W=2.
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        @(negedge clk);
        a = idle;
        a.vld = 1'b1; a.rs = 5'd5; a.urs = 1'b1; a.rt = 5'd5;
        a.wr = 5'd5; a.rw = 1'b1; a.m2r = 1'b1;
        b = a;
        for (int k = 0; k < 5; k++) begin
            drive(a);                      // EX empty: no hazard, lw enters EX
            #1;
            check($sformatf("cnt%0d no-hz pc_write", k), pc_write, 1);
            @(negedge clk);
            drive(b);                      // lw $5 in EX, ID reads $5: hazard
            #1;
            check($sformatf("cnt%0d hz pc_write", k), pc_write, 0);
            @(negedge clk);
`ifdef HAZARD_STATS_EN
            exp_cnt = (k + 1 > 3) ? 3 : k + 1;
`else
            exp_cnt = 0;
`endif
            check($sformatf("cnt%0d stall_cycles", k), stall_cycles, exp_cnt);
        end

        // Reset clears the counter.
        rst = 1'b1;
        @(negedge clk);
        check("cnt reset stall_cycles", stall_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
